decode_stage_pipe: RTL

//  Pipelined RV32I decode stage, successor to the single-cycle decode path.

---
 rtl/decode_stage_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: register file with write-back bypass, control decode, immediate
// generation and an ID/EX register with valid/ready handshake. Optional macro: LOAD_USE_STALL_EN.
module decode_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   imm_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [2:0]        funct3_out,
  output logic              funct7b5_out,
  output logic              ALUSrc,
  output logic              MemToReg,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic [1:0]        ALUOp,
  output logic              illegal
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [2:0]        f3;
    logic              f7b5;
    logic              alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]        alu_op;
    logic              illegal;
  } idex_t;

  logic [NREG-1:0][XLEN-1:0] rf_q, rf_d;
  idex_t                     pl_q, pl_d;
  logic                      out_valid_q, out_valid_d;
  logic [6:0]                opcode;
  logic [REG_AW-1:0]         rs1_idx, rs2_idx;
  logic [XLEN-1:0]           rs1_val, rs2_val;
  logic                      stall, take;

  assign opcode  = instr[6:0];
  assign rs1_idx = REG_AW'(instr[19:15]);
  assign rs2_idx = REG_AW'(instr[24:20]);

  // x0 is never written, so it stays at its reset value of zero
  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_rd != '0 && int'(wb_rd) < NREG) rf_d[wb_rd] = wb_data;
  end

  // same-cycle write-back forwards around the register file
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != '0 && int'(rs1_idx) < NREG)
      rs1_val = (wb_we && wb_rd == rs1_idx) ? wb_data : rf_q[rs1_idx];
    if (rs2_idx != '0 && int'(rs2_idx) < NREG)
      rs2_val = (wb_we && wb_rd == rs2_idx) ? wb_data : rf_q[rs2_idx];
  end

`ifdef LOAD_USE_STALL_EN
  logic uses_rs1, uses_rs2;
  always_comb begin
    uses_rs1 = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
               (opcode == OP_ST) || (opcode == OP_BR);
    uses_rs2 = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);
    stall    = out_valid_q && pl_q.mem_read && pl_q.rd != '0 && in_valid &&
               ((uses_rs1 && pl_q.rd == rs1_idx) || (uses_rs2 && pl_q.rd == rs2_idx));
  end
`else
  assign stall = 1'b0;
`endif

  assign in_ready = !flush && (!out_valid_q || out_ready) && !stall;
  assign take     = in_valid && in_ready;

  always_comb begin
    pl_d = pl_q;
    if (take) begin
      pl_d.pc   = pc_in;
      pl_d.rs1  = rs1_val;
      pl_d.rs2  = rs2_val;
      pl_d.rd   = REG_AW'(instr[11:7]);
      pl_d.f3   = instr[14:12];
      pl_d.f7b5 = instr[30];
      {pl_d.alu_src, pl_d.mem_to_reg, pl_d.reg_write, pl_d.mem_read,
       pl_d.mem_write, pl_d.branch, pl_d.alu_op, pl_d.illegal} = 9'b0;
      pl_d.imm  = '0;
      case (opcode)
        OP_R:  {pl_d.reg_write, pl_d.alu_op} = 3'b1_10;
        OP_I: begin
          {pl_d.alu_src, pl_d.reg_write, pl_d.alu_op} = 4'b1_1_10;
          pl_d.imm = XLEN'($signed(instr[31:20]));
        end
        OP_LD: begin
          {pl_d.alu_src, pl_d.mem_to_reg, pl_d.reg_write, pl_d.mem_read} = 4'b1111;
          pl_d.imm = XLEN'($signed(instr[31:20]));
        end
        OP_ST: begin
          {pl_d.alu_src, pl_d.mem_write} = 2'b11;
          pl_d.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        end
        OP_BR: begin
          {pl_d.branch, pl_d.alu_op} = 3'b1_01;
          pl_d.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        end
        default: pl_d.illegal = 1'b1;
      endcase
    end
  end

  // flush outranks everything; a transfer out with nothing new leaves a bubble
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (take)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q        <= '0;
      pl_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      pl_q        <= pl_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign pc_out       = pl_q.pc;
  assign rs1_data     = pl_q.rs1;
  assign rs2_data     = pl_q.rs2;
  assign imm_out      = pl_q.imm;
  assign rd_out       = pl_q.rd;
  assign funct3_out   = pl_q.f3;
  assign funct7b5_out = pl_q.f7b5;
  assign ALUSrc       = pl_q.alu_src;
  assign MemToReg     = pl_q.mem_to_reg;
  assign RegWrite     = pl_q.reg_write;
  assign MemRead      = pl_q.mem_read;
  assign MemWrite     = pl_q.mem_write;
  assign Branch       = pl_q.branch;
  assign ALUOp        = pl_q.alu_op;
  assign illegal      = pl_q.illegal;
endmodule
